spi_slave: RTL and testbench



---
 rtl/spi_slave_if.sv | 34 +++
 rtl/spi_slave.sv | 163 ++++++++++++++++
 tb/tb_spi_slave.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI pin and controller byte-bus bundle for spi_slave.
// The host/controller side uses the master modport and the slave block uses the slave modport.
interface spi_slave_if;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    wire        spi_miso;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       rx_stb;
    logic       tsx_start;

    modport slave (
        input  spi_sck,
        input  spi_cs_n,
        input  spi_mosi,
        input  tx_byte,
        output spi_miso,
        output rx_byte,
        output rx_stb,
        output tsx_start
    );

    modport master (
        output spi_sck,
        output spi_cs_n,
        output spi_mosi,
        output tx_byte,
        input  spi_miso,
        input  rx_byte,
        input  rx_stb,
        input  tsx_start
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave oversampled on clk: bytes out on rx_byte/rx_stb, reply byte in on tx_byte.
// Optional SPI_MISO_HIZ_EN: MISO floats while deselected or in reset (shared MISO line).
//
// state   | meaning
// S_IDLE  | deselected, or selected but waiting for a fresh CS fall
// S_LOAD  | one wait cycle for the controller's reply, then load tx_shift
// S_SHIFT | shifting bits on detected SCK edges
module spi_slave #(
    parameter int SYNC_STAGES = 2   // legal range 2..3
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    localparam logic [1:0] FILL_DONE = 2'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_q;
    logic                   cs_q;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_fall;

    logic [1:0]             fill_cnt;
    logic                   armed;

    logic [1:0]             state;
    logic                   load_wait;
    logic [7:0]             tx_shift;
    logic [7:0]             rx_shift;
    logic [2:0]             bit_cnt;
    logic                   reload;
    logic [7:0]             rx_byte_r;
    logic                   rx_stb_r;
    logic                   tsx_start_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  bus.spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            sck_q     <= sck_s;
            cs_q      <= cs_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;

    // The chain resets to CS=1, so a CS_N held low through reset would look like a
    // fall once the chain flushes. Only arm after a real high level has been seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= 2'd0;
            armed    <= 1'b0;
        end else begin
            if (fill_cnt != FILL_DONE)
                fill_cnt <= fill_cnt + 2'd1;
            else if (cs_s)
                armed <= 1'b1;
        end
    end

    assign cs_fall = armed & cs_q & ~cs_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            load_wait   <= 1'b0;
            tx_shift    <= 8'h00;
            rx_shift    <= 8'h00;
            bit_cnt     <= 3'd0;
            reload      <= 1'b0;
            rx_byte_r   <= 8'h00;
            rx_stb_r    <= 1'b0;
            tsx_start_r <= 1'b0;
        end else begin
            rx_stb_r    <= 1'b0;
            tsx_start_r <= 1'b0;
            if (cs_s) begin
                // Deselect wins over any same-cycle SCK edge; a partial byte is dropped.
                state     <= S_IDLE;
                load_wait <= 1'b0;
                rx_shift  <= 8'h00;
                bit_cnt   <= 3'd0;
                reload    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state       <= S_LOAD;
                            load_wait   <= 1'b0;
                            tsx_start_r <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (!load_wait) begin
                            load_wait <= 1'b1;
                        end else begin
                            load_wait <= 1'b0;
                            tx_shift  <= bus.tx_byte;
                            bit_cnt   <= 3'd0;
                            reload    <= 1'b0;
                            state     <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (sck_rise) begin
                            rx_shift <= {rx_shift[6:0], mosi_s};
                            if (bit_cnt == 3'd7) begin
                                rx_byte_r <= {rx_shift[6:0], mosi_s};
                                rx_stb_r  <= 1'b1;
                                bit_cnt   <= 3'd0;
                                reload    <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (sck_fall) begin
                            if (reload) begin
                                tx_shift <= bus.tx_byte;
                                reload   <= 1'b0;
                            end else begin
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_byte   = rx_byte_r;
    assign bus.rx_stb    = rx_stb_r;
    assign bus.tsx_start = tsx_start_r;

`ifdef SPI_MISO_HIZ_EN
    assign bus.spi_miso = (cs_s || rst) ? 1'bz : tx_shift[7];
`else
    assign bus.spi_miso = cs_s ? 1'b0 : tx_shift[7];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a host model drives the SPI pins, and a monitor logs the strobes.
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_slave_if bus ();

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SPI_MISO_HIZ_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int         cyc       = 0;
    int         stb_cnt   = 0;
    int         tsx_cnt   = 0;
    int         close_cnt = 0;
    logic [7:0] rx_log[$];
    int         stb_time[$];
    logic       p1 = 1'b0;
    logic       p2 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.rx_stb === 1'b1) begin
            stb_cnt++;
            rx_log.push_back(bus.rx_byte);
            stb_time.push_back(cyc);
            if (p1 || p2) close_cnt++;
        end
        if (bus.tsx_start === 1'b1) tsx_cnt++;
        p2 = p1;
        p1 = (bus.rx_stb === 1'b1);
    end

    // Controller model: a queued reply byte is presented 1 clk after each strobe.
    logic [7:0] tx_q[$];
    logic       stb_last = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        if (stb_last && tx_q.size() > 0) bus.tx_byte = tx_q.pop_front();
        stb_last = (bus.rx_stb === 1'b1);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) step();
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, input int hi, input int lo,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.spi_mosi = mo[i];
            wait_clk(lo);
            mi = {mi[6:0], bus.spi_miso};
            bus.spi_sck = 1'b1;
            wait_clk(hi);
            bus.spi_sck = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] mi;
        int         s0;
        int         t0;
        int         base;
        logic [7:0] exp_sp[4];

        rst          = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_byte  = 8'hA5;
        wait_clk(4);
        chk("rst_rx_byte", 32'(bus.rx_byte), 32'h00);
        chk("rst_rx_stb", 32'(bus.rx_stb), 32'h0);
        chk("rst_tsx_start", 32'(bus.tsx_start), 32'h0);
        chk("rst_miso", 32'(bus.spi_miso), 32'(MISO_IDLE));
        rst = 1'b0;
        wait_clk(6);
        chk("idle_miso", 32'(bus.spi_miso), 32'(MISO_IDLE));

        // single byte
        bus.spi_cs_n = 1'b0;
        wait_clk(7);
        chk("sel_miso_msb", 32'(bus.spi_miso), 32'h1);
        xfer(8'h3C, 8, 4, 4, mi);
        wait_clk(6);
        bus.spi_cs_n = 1'b1;
        wait_clk(6);
        chk("single_tsx", 32'(tsx_cnt), 32'd1);
        chk("single_stb", 32'(stb_cnt), 32'd1);
        chk("single_rx", 32'(rx_log[0]), 32'h3C);
        chk("single_miso", 32'(mi), 32'hA5);
        chk("desel_miso", 32'(bus.spi_miso), 32'(MISO_IDLE));

        // back-to-back bytes with reply updates
        tx_q.push_back(8'h10);
        tx_q.push_back(8'h20);
        bus.spi_cs_n = 1'b0;
        wait_clk(7);
        xfer(8'h01, 8, 4, 4, mi);
        chk("b2b_miso0", 32'(mi), 32'hA5);
        xfer(8'h02, 8, 4, 4, mi);
        chk("b2b_miso1", 32'(mi), 32'h10);
        xfer(8'hFF, 8, 4, 4, mi);
        chk("b2b_miso2", 32'(mi), 32'h20);
        wait_clk(6);
        bus.spi_cs_n = 1'b1;
        wait_clk(6);
        chk("b2b_stb", 32'(stb_cnt), 32'd4);
        chk("b2b_rx0", 32'(rx_log[1]), 32'h01);
        chk("b2b_rx1", 32'(rx_log[2]), 32'h02);
        chk("b2b_rx2", 32'(rx_log[3]), 32'hFF);
        chk("b2b_tsx", 32'(tsx_cnt), 32'd2);

        // abort after 5 rises, then a clean transfer
        s0 = stb_cnt;
        bus.spi_cs_n = 1'b0;
        wait_clk(7);
        xfer(8'hF0, 5, 4, 4, mi);
        wait_clk(2);
        bus.spi_cs_n = 1'b1;
        wait_clk(6);
        chk("abort_stb", 32'(stb_cnt), 32'(s0));
        chk("abort_bitcnt", 32'(dut.bit_cnt), 32'd0);
        bus.tx_byte  = 8'h81;
        bus.spi_cs_n = 1'b0;
        wait_clk(7);
        xfer(8'h81, 8, 4, 4, mi);
        wait_clk(6);
        bus.spi_cs_n = 1'b1;
        wait_clk(6);
        chk("after_abort_stb", 32'(stb_cnt), 32'(s0 + 1));
        chk("after_abort_rx", 32'(rx_log[s0]), 32'h81);
        chk("after_abort_miso", 32'(mi), 32'h81);

        // 8th rise and CS deassert land on the same cycle: no strobe
        s0 = stb_cnt;
        bus.spi_cs_n = 1'b0;
        wait_clk(7);
        xfer(8'hFE, 7, 4, 4, mi);
        bus.spi_mosi = 1'b1;
        wait_clk(4);
        bus.spi_sck  = 1'b1;
        bus.spi_cs_n = 1'b1;
        wait_clk(6);
        bus.spi_sck = 1'b0;
        wait_clk(6);
        chk("cs_wins_stb", 32'(stb_cnt), 32'(s0));

        // reset in the middle of a byte
        bus.tx_byte  = 8'hC3;
        bus.spi_cs_n = 1'b0;
        wait_clk(7);
        s0 = stb_cnt;
        t0 = tsx_cnt;
        xfer(8'h99, 4, 4, 4, mi);
        rst = 1'b1;
        wait_clk(2);
        chk("midrst_rx_byte", 32'(bus.rx_byte), 32'h00);
        chk("midrst_rx_stb", 32'(bus.rx_stb), 32'h0);
        chk("midrst_tsx", 32'(bus.tsx_start), 32'h0);
        chk("midrst_miso", 32'(bus.spi_miso), 32'(MISO_IDLE));
        rst = 1'b0;
        wait_clk(12);
        chk("midrst_no_tsx", 32'(tsx_cnt), 32'(t0));
        chk("midrst_no_stb", 32'(stb_cnt), 32'(s0));
        bus.spi_cs_n = 1'b1;
        wait_clk(6);
        bus.spi_cs_n = 1'b0;
        wait_clk(7);
        chk("midrst_retsx", 32'(tsx_cnt), 32'(t0 + 1));
        xfer(8'h5A, 8, 4, 4, mi);
        wait_clk(6);
        bus.spi_cs_n = 1'b1;
        wait_clk(6);
        chk("midrst_miso_byte", 32'(mi), 32'hC3);
        chk("midrst_rx", 32'(rx_log[s0]), 32'h5A);

        // strobe spacing at minimum SCK timing
        exp_sp[0] = 8'h11;
        exp_sp[1] = 8'h22;
        exp_sp[2] = 8'h33;
        exp_sp[3] = 8'h44;
        base = stb_time.size();
        bus.spi_cs_n = 1'b0;
        wait_clk(7);
        for (int k = 0; k < 4; k++) xfer(exp_sp[k], 8, 3, 3, mi);
        wait_clk(6);
        bus.spi_cs_n = 1'b1;
        wait_clk(6);
        chk("sp_stb_cnt", 32'(stb_time.size() - base), 32'd4);
        if (stb_time.size() - base == 4) begin
            for (int k = 1; k < 4; k++)
                chk("sp_gap", 32'(stb_time[base + k] - stb_time[base + k - 1]), 32'd48);
            for (int k = 0; k < 4; k++)
                chk("sp_rx", 32'(rx_log[base + k]), 32'(exp_sp[k]));
        end
        chk("stb_close", 32'(close_cnt), 32'd0);
        chk("final_miso_idle", 32'(bus.spi_miso), 32'(MISO_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
